mem_port_arbiter: RTL and testbench

- Shares one single-ported synchronous-read memory between two requesters: the CPU instruction-fetch channel (read-only) and the CPU data channel (read/write).
- Sits between a multicycle CPU core and a single-port memory macro in the emulation top, replacing dual-read-port ideal memory.
- Valid/ready request channels, registered read-response channels, round-robin arbitration on contention, and a saturating contention counter.

---
 rtl/mem_port_arbiter.sv | 117 +++++++++++
 tb/tb_mem_port_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-channel arbiter in front of a single-port synchronous-read memory.
// Fetch is read-only and data is read/write. Contested grants alternate between channels.
module mem_port_arbiter #(
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32,
  parameter int unsigned MAW = 10,
  parameter int unsigned CW  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req_valid,
  output logic            if_req_ready,
  input  logic [AW-1:0]   if_req_addr,
  output logic            if_rsp_valid,
  input  logic            if_rsp_ready,
  output logic [DW-1:0]   if_rsp_data,
  input  logic            d_req_valid,
  output logic            d_req_ready,
  input  logic [AW-1:0]   d_req_addr,
  input  logic            d_req_wen,
  input  logic [DW-1:0]   d_req_wdata,
  input  logic [DW/8-1:0] d_req_wstrb,
  output logic            d_rsp_valid,
  input  logic            d_rsp_ready,
  output logic [DW-1:0]   d_rsp_data,
  output logic            mem_en,
  output logic            mem_wen,
  output logic [MAW-1:0]  mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  input  logic [DW-1:0]   mem_rdata,
  output logic [CW-1:0]   contention_cnt
);

  typedef enum logic [1:0] {StIdle, StRd, StRsp} state_e;

  localparam logic GntIf = 1'b0;
  localparam logic GntD  = 1'b1;

  state_e          r_state, w_state_next;
  logic            r_last_grant;
  logic            r_owner;
  logic            r_if_rsp_valid, r_d_rsp_valid;
  logic [DW-1:0]   r_if_rsp_data, r_d_rsp_data;
  logic [CW-1:0]   r_cnt;

  logic            w_idle, w_both, w_gnt_if, w_gnt_d, w_gnt_rd, w_rsp_ready;
  logic            w_unused_addr;

  assign w_both = if_req_valid && d_req_valid;
  // Reset gates the grant so no memory access leaks out while rst is high.
  assign w_idle   = (r_state == StIdle) && !rst;
  assign w_gnt_d  = w_idle && d_req_valid && (!if_req_valid || (r_last_grant == GntIf));
  assign w_gnt_if = w_idle && if_req_valid && !w_gnt_d;
  assign w_gnt_rd = w_gnt_if || (w_gnt_d && !d_req_wen);

  assign w_rsp_ready = (r_owner == GntD) ? d_rsp_ready : if_rsp_ready;

  assign w_unused_addr = ^{if_req_addr[AW-1:MAW+2], if_req_addr[1:0],
                           d_req_addr[AW-1:MAW+2], d_req_addr[1:0]};

  assign if_req_ready = w_gnt_if;
  assign d_req_ready  = w_gnt_d;
  assign mem_en       = w_gnt_if || w_gnt_d;
  assign mem_wen      = w_gnt_d && d_req_wen;
  assign mem_addr     = w_gnt_d ? d_req_addr[MAW+1:2] : if_req_addr[MAW+1:2];
  assign mem_wdata    = d_req_wdata;
  assign mem_wstrb    = d_req_wstrb;

  assign if_rsp_valid   = r_if_rsp_valid;
  assign if_rsp_data    = r_if_rsp_data;
  assign d_rsp_valid    = r_d_rsp_valid;
  assign d_rsp_data     = r_d_rsp_data;
  assign contention_cnt = r_cnt;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (w_gnt_rd) w_state_next = StRd;
      StRd:    w_state_next = StRsp;
      StRsp:   if (w_rsp_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= StIdle;
      r_last_grant   <= GntIf;
      r_owner        <= GntIf;
      r_if_rsp_valid <= 1'b0;
      r_d_rsp_valid  <= 1'b0;
      r_if_rsp_data  <= '0;
      r_d_rsp_data   <= '0;
      r_cnt          <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_gnt_if || w_gnt_d) r_last_grant <= w_gnt_d;
      if (w_gnt_rd) r_owner <= w_gnt_d;
      if (r_state == StRd) begin
        if (r_owner == GntD) begin
          r_d_rsp_data  <= mem_rdata;
          r_d_rsp_valid <= 1'b1;
        end else begin
          r_if_rsp_data  <= mem_rdata;
          r_if_rsp_valid <= 1'b1;
        end
      end
      if ((r_state == StRsp) && w_rsp_ready) begin
        r_if_rsp_valid <= 1'b0;
        r_d_rsp_valid  <= 1'b0;
      end
      if ((r_state == StIdle) && w_both && (r_cnt != {CW{1'b1}})) r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural single-port memory.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_ready;
  logic [31:0] if_req_addr, if_rsp_data;
  logic        d_req_valid, d_req_ready, d_req_wen, d_rsp_valid, d_rsp_ready;
  logic [31:0] d_req_addr, d_req_wdata, d_rsp_data;
  logic [3:0]  d_req_wstrb;
  logic        mem_en, mem_wen;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] contention_cnt;

  int   checks = 0;
  int   errors = 0;
  logic exp_d;

  logic [31:0] mem [0:1023];

  mem_port_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .if_req_valid   (if_req_valid),
    .if_req_ready   (if_req_ready),
    .if_req_addr    (if_req_addr),
    .if_rsp_valid   (if_rsp_valid),
    .if_rsp_ready   (if_rsp_ready),
    .if_rsp_data    (if_rsp_data),
    .d_req_valid    (d_req_valid),
    .d_req_ready    (d_req_ready),
    .d_req_addr     (d_req_addr),
    .d_req_wen      (d_req_wen),
    .d_req_wdata    (d_req_wdata),
    .d_req_wstrb    (d_req_wstrb),
    .d_rsp_valid    (d_rsp_valid),
    .d_rsp_ready    (d_rsp_ready),
    .d_rsp_data     (d_rsp_data),
    .mem_en         (mem_en),
    .mem_wen        (mem_wen),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_wstrb      (mem_wstrb),
    .mem_rdata      (mem_rdata),
    .contention_cnt (contention_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[3] = 32'h11223344;
    mem[4] = 32'h2402000C;
    mem[5] = 32'hAAAA5555;
    mem_rdata = 32'h0;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wen) begin
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    if_req_valid = 1'b0; if_req_addr = 32'h0; if_rsp_ready = 1'b1;
    d_req_valid = 1'b0; d_req_addr = 32'h0; d_req_wen = 1'b0;
    d_req_wdata = 32'h0; d_req_wstrb = 4'h0; d_rsp_ready = 1'b1;
    step(); step();

    // Reset state, with both requesters asserting to prove nothing leaks out.
    if_req_valid = 1'b1; if_req_addr = 32'h10;
    d_req_valid  = 1'b1; d_req_addr  = 32'h14;
    #1;
    chk("rst_mem_en", {31'h0, mem_en}, 32'h0);
    chk("rst_if_req_ready", {31'h0, if_req_ready}, 32'h0);
    chk("rst_d_req_ready", {31'h0, d_req_ready}, 32'h0);
    chk("rst_if_rsp_valid", {31'h0, if_rsp_valid}, 32'h0);
    chk("rst_d_rsp_valid", {31'h0, d_rsp_valid}, 32'h0);
    chk("rst_if_rsp_data", if_rsp_data, 32'h0);
    chk("rst_d_rsp_data", d_rsp_data, 32'h0);
    chk("rst_cnt", contention_cnt, 32'h0);

    // Contested reads: grant order D, IF, D, IF.
    step();
    rst = 1'b0;
    for (int g = 0; g < 4; g++) begin
      exp_d = (g % 2 == 0);
      #1;
      chk("con_d_ready", {31'h0, d_req_ready}, {31'h0, exp_d});
      chk("con_if_ready", {31'h0, if_req_ready}, {31'h0, !exp_d});
      chk("con_mem_addr", {22'h0, mem_addr}, exp_d ? 32'd5 : 32'd4);
      chk("con_cnt_idle", contention_cnt, g);
      step(); #1;
      chk("con_cnt_rd", contention_cnt, g + 1);
      chk("con_rd_ready", {30'h0, if_req_ready, d_req_ready}, 32'h0);
      step(); #1;
      chk("con_rsp_valid", {30'h0, d_rsp_valid, if_rsp_valid}, exp_d ? 32'h2 : 32'h1);
      chk("con_rsp_data", exp_d ? d_rsp_data : if_rsp_data,
          exp_d ? 32'hAAAA5555 : 32'h2402000C);
      chk("con_cnt_rsp", contention_cnt, g + 1);
      if (g == 3) begin
        if_req_valid = 1'b0;
        d_req_valid  = 1'b0;
      end
      step();
    end
    #1;
    chk("con_cnt_final", contention_cnt, 32'd4);
    chk("con_idle_mem_en", {31'h0, mem_en}, 32'h0);

    // Uncontested fetch read of word 4.
    step();
    if_req_valid = 1'b1; if_req_addr = 32'h10;
    #1;
    chk("if_req_ready", {31'h0, if_req_ready}, 32'h1);
    chk("if_mem_en", {31'h0, mem_en}, 32'h1);
    chk("if_mem_wen", {31'h0, mem_wen}, 32'h0);
    chk("if_mem_addr", {22'h0, mem_addr}, 32'd4);
    step();
    if_req_valid = 1'b0;
    #1;
    chk("if_rd_valid", {31'h0, if_rsp_valid}, 32'h0);
    step(); #1;
    chk("if_rsp_valid", {31'h0, if_rsp_valid}, 32'h1);
    chk("if_rsp_data", if_rsp_data, 32'h2402000C);
    step(); #1;
    chk("if_rsp_done", {31'h0, if_rsp_valid}, 32'h0);

    // Partial write of word 3, then read it back on the very next cycle.
    step();
    d_req_valid = 1'b1; d_req_addr = 32'hC; d_req_wen = 1'b1;
    d_req_wdata = 32'hDEADBEEF; d_req_wstrb = 4'b0011;
    #1;
    chk("wr_ready", {31'h0, d_req_ready}, 32'h1);
    chk("wr_mem_wen", {31'h0, mem_wen}, 32'h1);
    chk("wr_mem_addr", {22'h0, mem_addr}, 32'd3);
    chk("wr_mem_wstrb", {28'h0, mem_wstrb}, 32'h3);
    chk("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
    step();
    d_req_wen = 1'b0;
    #1;
    chk("wr_then_rd_ready", {31'h0, d_req_ready}, 32'h1);
    chk("wr_then_rd_wen", {31'h0, mem_wen}, 32'h0);
    step();
    d_req_valid = 1'b0;
    #1;
    chk("wr_rd_no_rsp", {31'h0, d_rsp_valid}, 32'h0);
    step(); #1;
    chk("wr_rd_valid", {30'h0, d_rsp_valid, if_rsp_valid}, 32'h2);
    chk("wr_rd_data", d_rsp_data, 32'h1122BEEF);
    step(); #1;
    chk("wr_rd_done", {31'h0, d_rsp_valid}, 32'h0);

    // Fetch response held five cycles by a stalled consumer while data waits.
    step();
    if_req_valid = 1'b1; if_req_addr = 32'h10; if_rsp_ready = 1'b0;
    #1;
    chk("st_if_ready", {31'h0, if_req_ready}, 32'h1);
    step();
    if_req_valid = 1'b0;
    d_req_valid = 1'b1; d_req_addr = 32'h14; d_req_wen = 1'b0;
    #1;
    chk("st_rd_d_ready", {31'h0, d_req_ready}, 32'h0);
    for (int k = 0; k < 5; k++) begin
      step(); #1;
      chk("st_valid", {31'h0, if_rsp_valid}, 32'h1);
      chk("st_data", if_rsp_data, 32'h2402000C);
      chk("st_readies", {30'h0, if_req_ready, d_req_ready}, 32'h0);
      chk("st_mem_en", {31'h0, mem_en}, 32'h0);
    end
    if_rsp_ready = 1'b1;
    step(); #1;
    chk("st_released", {31'h0, if_rsp_valid}, 32'h0);
    chk("st_d_granted", {31'h0, d_req_ready}, 32'h1);
    chk("st_cnt", contention_cnt, 32'd4);
    step();
    d_req_valid = 1'b0;
    step(); #1;
    chk("st_d_rsp_valid", {31'h0, d_rsp_valid}, 32'h1);
    chk("st_d_rsp_data", d_rsp_data, 32'hAAAA5555);

    // Reset while a fetch read is in flight.
    step();
    if_req_valid = 1'b1; if_req_addr = 32'h10;
    #1;
    chk("rr_if_ready", {31'h0, if_req_ready}, 32'h1);
    step();
    if_req_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("rr_if_valid", {31'h0, if_rsp_valid}, 32'h0);
    chk("rr_if_data", if_rsp_data, 32'h0);
    chk("rr_d_data", d_rsp_data, 32'h0);
    chk("rr_cnt", contention_cnt, 32'h0);
    chk("rr_mem_en", {31'h0, mem_en}, 32'h0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("rr_no_rsp", {30'h0, d_rsp_valid, if_rsp_valid}, 32'h0);
      step();
    end
    d_req_valid = 1'b1; d_req_addr = 32'hC; d_req_wen = 1'b0;
    #1;
    chk("rr_d_ready", {31'h0, d_req_ready}, 32'h1);
    chk("rr_d_addr", {22'h0, mem_addr}, 32'd3);
    step();
    d_req_valid = 1'b0;
    step(); #1;
    chk("rr_d_rsp_valid", {30'h0, d_rsp_valid, if_rsp_valid}, 32'h2);
    chk("rr_d_rsp_data", d_rsp_data, 32'h1122BEEF);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
